// File: rtl/rsa_mont_exp.sv
// rsa_mont_exp -- modular exponentiator, o_out = msg^key mod N.
//
// Uses a radix-2 bit-serial Montgomery multiplier (WIDTH+1 cycles per
// product) and LSB-first square-and-multiply. Multiplies are skipped for
// zero key bits. Total latency is NMUL*(WIDTH+1) cycles from the accept edge,
// where NMUL = 3 + popcount(key[key_len-1:0]) + max(key_len-1, 0).
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_valid/i_ready request handshake (i_ready only in IDLE)
//   i_r2            R^2 mod N, R = 2^WIDTH
//   i_msg           message, < N
//   i_key           exponent bits
//   i_key_len       exponent bits used (clamped to WIDTH)
//   i_modulus       N, odd, > 1
//   o_valid/o_ready result handshake; o_out held until o_ready
//   o_out           result, updated only when a new result is produced
//   o_cycles        cycles of the last operation (RSA_MONT_EXP_PERF_EN only)
//
// Optional build macro: RSA_MONT_EXP_PERF_EN adds o_cycles and its counter.
//
// state | meaning
// IDLE  | waiting for a request, i_ready=1
// TOM   | S = MontMul(msg, r2)   (message into Montgomery domain)
// ONE   | M = MontMul(r2, 1)     (R mod N, i.e. Montgomery one)
// MUL   | M = MontMul(M, S)      (key bit i is set)
// SQR   | S = MontMul(S, S)      (more key bits follow)
// FROM  | o_out = MontMul(M, 1)  (back out of Montgomery domain)
// DONE  | o_valid=1, waiting for o_ready

module rsa_mont_exp #(
  parameter int WIDTH = 256,
  parameter int KLW   = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_r2,
  input  logic [WIDTH-1:0] i_msg,
  input  logic [WIDTH-1:0] i_key,
  input  logic [KLW-1:0]   i_key_len,
  input  logic [WIDTH-1:0] i_modulus,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_out
`ifdef RSA_MONT_EXP_PERF_EN
  ,
  output logic [31:0]      o_cycles
`endif
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [KLW-1:0] K_ONE = KLW'(1);
  localparam logic [CW-1:0]  C_ONE = CW'(1);
  localparam logic [CW-1:0]  C_END = CW'(WIDTH);
  localparam logic [KLW-1:0] K_MAX = KLW'(WIDTH);

  typedef enum logic [2:0] {IDLE, TOM, ONE, MUL, SQR, FROM, DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] msg_q, r2_q, key_q, n_q, s_q, m_q;
  logic [KLW-1:0]   klen_q, idx_q, entry_idx;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH+1:0] t_q, t_sum, t_iter, t_corr;
  logic [WIDTH-1:0] a_sel, b_sel, mm_res;
  logic             a_bit, key_bit, accept, busy, mul_done;
  state_t           entry_st;

  assign accept   = (state_q == IDLE) && i_valid;
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign mul_done = busy && (cnt_q == C_END);

  // Operand selection; M and S only change on multiply completion edges,
  // so the next multiply can start with no bubble.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    case (state_q)
      TOM:  begin a_sel = msg_q; b_sel = r2_q; end
      ONE:  begin a_sel = r2_q;  b_sel = WIDTH'(1); end
      MUL:  begin a_sel = m_q;   b_sel = s_q; end
      SQR:  begin a_sel = s_q;   b_sel = s_q; end
      FROM: begin a_sel = m_q;   b_sel = WIDTH'(1); end
      default: ;
    endcase
  end

  // cnt_q == WIDTH masks to zero, which is harmless in the correction cycle.
  assign a_bit  = |(a_sel & (WIDTH'(1) << cnt_q));
  assign t_sum  = t_q + (a_bit ? {2'b00, b_sel} : '0);
  assign t_iter = (t_sum[0] ? (t_sum + {2'b00, n_q}) : t_sum) >> 1;
  assign t_corr = (t_q >= {2'b00, n_q}) ? (t_q - {2'b00, n_q}) : t_q;
  assign mm_res = t_corr[WIDTH-1:0];

  // Where the exponent loop goes next, evaluated for bit index entry_idx:
  // index 0 when leaving ONE, idx+1 when leaving SQR.
  assign entry_idx = (state_q == ONE) ? '0 : (idx_q + K_ONE);
  assign key_bit   = |(key_q & (WIDTH'(1) << entry_idx));

  always_comb begin
    if (entry_idx >= klen_q)               entry_st = FROM;
    else if (key_bit)                      entry_st = MUL;
    else if ((entry_idx + K_ONE) < klen_q) entry_st = SQR;
    else                                   entry_st = FROM;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_valid)  state_d = TOM;
      TOM:  if (mul_done) state_d = ONE;
      ONE:  if (mul_done) state_d = entry_st;
      MUL:  if (mul_done) state_d = ((idx_q + K_ONE) < klen_q) ? SQR : FROM;
      SQR:  if (mul_done) state_d = entry_st;
      FROM: if (mul_done) state_d = DONE;
      DONE: if (o_ready)  state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  always_comb begin
    i_ready = (state_q == IDLE);
    o_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_q  <= '0;
      r2_q   <= '0;
      key_q  <= '0;
      n_q    <= '0;
      klen_q <= '0;
      s_q    <= '0;
      m_q    <= '0;
      t_q    <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      o_out  <= '0;
    end else if (accept) begin
      msg_q  <= i_msg;
      r2_q   <= i_r2;
      key_q  <= i_key;
      n_q    <= i_modulus;
      klen_q <= (i_key_len > K_MAX) ? K_MAX : i_key_len;
      t_q    <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
    end else if (busy) begin
      if (!mul_done) begin
        t_q   <= t_iter;
        cnt_q <= cnt_q + C_ONE;
      end else begin
        t_q   <= '0;
        cnt_q <= '0;
        case (state_q)
          TOM:  s_q <= mm_res;
          ONE:  m_q <= mm_res;
          MUL:  m_q <= mm_res;
          SQR:  begin s_q <= mm_res; idx_q <= idx_q + K_ONE; end
          FROM: o_out <= mm_res;
          default: ;
        endcase
      end
    end
  end

`ifdef RSA_MONT_EXP_PERF_EN
  logic [31:0] cyc_q;

  // Not counting in DONE freezes the value for the result handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 cyc_q <= '0;
    else if (accept)                          cyc_q <= '0;
    else if (busy && (cyc_q != 32'hFFFF_FFFF)) cyc_q <= cyc_q + 32'd1;
  end

  assign o_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_rsa_mont_exp.sv
// Self-checking bench for rsa_mont_exp: WIDTH=8 directed vectors (N=187)
// plus a WIDTH=256 instance checked against a wide-arithmetic golden model.
module tb_rsa_mont_exp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=8 instance
  logic       i_valid_8, i_ready_8, o_valid_8, o_ready_8;
  logic [7:0] r2_8, msg_8, key_8, n_8, o_out_8;
  logic [3:0] klen_8;
  logic [31:0] cyc_8;

  // WIDTH=256 instance
  logic         i_valid_w, i_ready_w, o_valid_w, o_ready_w;
  logic [255:0] r2_w, msg_w, key_w, n_w, o_out_w;
  logic [8:0]   klen_w;
  logic [31:0]  cyc_w;

  rsa_mont_exp #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .i_valid(i_valid_8), .i_ready(i_ready_8),
    .i_r2(r2_8), .i_msg(msg_8), .i_key(key_8), .i_key_len(klen_8),
    .i_modulus(n_8),
    .o_valid(o_valid_8), .o_ready(o_ready_8), .o_out(o_out_8)
`ifdef RSA_MONT_EXP_PERF_EN
    , .o_cycles(cyc_8)
`endif
  );

  rsa_mont_exp #(.WIDTH(256)) dutw (
    .clk(clk), .rst(rst),
    .i_valid(i_valid_w), .i_ready(i_ready_w),
    .i_r2(r2_w), .i_msg(msg_w), .i_key(key_w), .i_key_len(klen_w),
    .i_modulus(n_w),
    .o_valid(o_valid_w), .o_ready(o_ready_w), .o_out(o_out_w)
`ifdef RSA_MONT_EXP_PERF_EN
    , .o_cycles(cyc_w)
`endif
  );

`ifndef RSA_MONT_EXP_PERF_EN
  initial begin
    cyc_8 = '0;
    cyc_w = '0;
  end
`endif

  typedef struct {
    string      name;
    logic [7:0] msg;
    logic [7:0] key;
    logic [3:0] klen;
    logic [7:0] exp_out;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid8(output int n);
    n = 0;
    while (!o_valid_8 && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Full request/response with o_ready held high.
  task automatic run8(input vec_t v);
    int k;
    int n;
    @(negedge clk);
    msg_8 = v.msg; key_8 = v.key; klen_8 = v.klen; i_valid_8 = 1'b1;
    k = 0;
    while (!i_ready_8 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({v.name, " ready"}, 256'(i_ready_8), 256'(1));
    @(negedge clk);
    i_valid_8 = 1'b0;
    wait_valid8(n);
    chk({v.name, " latency"}, 256'(n), 256'(v.exp_lat));
    chk({v.name, " out"}, 256'(o_out_8), 256'(v.exp_out));
`ifdef RSA_MONT_EXP_PERF_EN
    chk({v.name, " cycles"}, 256'(cyc_8), 256'(v.exp_lat));
`endif
    @(negedge clk);
    chk({v.name, " idle"}, 256'({i_ready_8, o_valid_8}), 256'(2'b10));
    chk({v.name, " held"}, 256'(o_out_8), 256'(v.exp_out));
  endtask

  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b,
                                          input logic [255:0] m);
    logic [511:0] p;
    p = {256'b0, a} * {256'b0, b};
    p = p % {256'b0, m};
    return p[255:0];
  endfunction

  function automatic logic [255:0] powmod(input logic [255:0] b, input logic [255:0] e,
                                          input logic [255:0] m);
    logic [255:0] r;
    logic [255:0] x;
    r = 256'(1) % m;
    x = b;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = mulmod(r, x, m);
      x = mulmod(x, x, m);
    end
    return r;
  endfunction

  initial begin
    int n;
    int pc;
    logic [512:0] big;
    logic [255:0] exp_w;

    rst = 1'b0;
    i_valid_8 = 0; o_ready_8 = 1; n_8 = 8'd187; r2_8 = 8'd86;
    msg_8 = 0; key_8 = 0; klen_8 = 0;
    i_valid_w = 0; o_ready_w = 1; n_w = '0; r2_w = '0; msg_w = '0; key_w = '0; klen_w = '0;

    vecs[0] = '{"enc",          8'd88, 8'd7,    4'd3,  8'd11, 72};
    vecs[1] = '{"dec",          8'd11, 8'd23,   4'd5,  8'd88, 99};
    vecs[2] = '{"dec_len3",     8'd11, 8'd23,   4'd3,  8'd88, 72};
    vecs[3] = '{"len0",         8'd88, 8'hC3,   4'd0,  8'd1,  27};
    vecs[4] = '{"key0_len4",    8'd88, 8'd0,    4'd4,  8'd1,  54};
    vecs[5] = '{"clamp15",      8'd88, 8'hA5,   4'd15, 8'd22, 126};
    vecs[6] = '{"len8",         8'd88, 8'hA5,   4'd8,  8'd22, 126};
    vecs[7] = '{"upper_ignored",8'd88, 8'hFF,   4'd3,  8'd11, 72};

    repeat (3) @(negedge clk);
    chk("reset ready/valid 8", 256'({i_ready_8, o_valid_8}), 256'(2'b10));
    chk("reset out 8", 256'(o_out_8), 256'(0));
    chk("reset ready/valid 256", 256'({i_ready_w, o_valid_w}), 256'(2'b10));
    chk("reset out 256", o_out_w, 256'(0));
`ifdef RSA_MONT_EXP_PERF_EN
    chk("reset cycles", 256'(cyc_8), 256'(0));
`endif
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run8(vecs[i]);

    // Backpressure: hold o_ready low with a new request pending.
    o_ready_8 = 1'b0;
    @(negedge clk);
    msg_8 = 8'd88; key_8 = 8'd7; klen_8 = 4'd3; i_valid_8 = 1'b1;
    @(negedge clk);
    msg_8 = 8'd11; key_8 = 8'd23; klen_8 = 4'd5;
    wait_valid8(n);
    chk("bp latency", 256'(n), 256'(72));
    for (int c = 0; c < 10; c++) begin
      chk("bp hold state", 256'({o_valid_8, i_ready_8}), 256'(2'b10));
      chk("bp hold out", 256'(o_out_8), 256'(11));
`ifdef RSA_MONT_EXP_PERF_EN
      chk("bp hold cycles", 256'(cyc_8), 256'(72));
`endif
      @(negedge clk);
    end
    o_ready_8 = 1'b1;
    @(negedge clk);
    chk("bp release", 256'({o_valid_8, i_ready_8}), 256'(2'b01));
    @(negedge clk);
    i_valid_8 = 1'b0;
    wait_valid8(n);
    chk("bp second latency", 256'(n), 256'(99));
    chk("bp second out", 256'(o_out_8), 256'(88));
    @(negedge clk);
    chk("bp second idle", 256'({i_ready_8, o_valid_8}), 256'(2'b10));

    // Reset in the middle of a decrypt.
    @(negedge clk);
    msg_8 = 8'd11; key_8 = 8'd23; klen_8 = 4'd5; i_valid_8 = 1'b1;
    @(negedge clk);
    i_valid_8 = 1'b0;
    repeat (30) @(negedge clk);
    chk("midop busy", 256'({i_ready_8, o_valid_8}), 256'(2'b00));
    #2 rst = 1'b0;
    #1;
    chk("midop rst state", 256'({i_ready_8, o_valid_8}), 256'(2'b10));
    chk("midop rst out", 256'(o_out_8), 256'(0));
`ifdef RSA_MONT_EXP_PERF_EN
    chk("midop rst cycles", 256'(cyc_8), 256'(0));
`endif
    @(negedge clk);
    rst = 1'b1;
    run8(vecs[0]);

    // WIDTH=256 smoke test against the wide golden model.
    for (int i = 0; i < 8; i++) n_w[i*32 +: 32] = $urandom;
    n_w[255] = 1'b1;
    n_w[0] = 1'b1;
    for (int i = 0; i < 8; i++) msg_w[i*32 +: 32] = $urandom;
    msg_w = msg_w % n_w;
    key_w = '0;
    key_w[255] = 1'b1;
    key_w[100] = 1'b1;
    key_w[16] = 1'b1;
    key_w[0] = 1'b1;
    big = '0;
    big[512] = 1'b1;
    big = big % {257'b0, n_w};
    r2_w = big[255:0];
    exp_w = powmod(msg_w, key_w, n_w);
    pc = 0;
    for (int i = 0; i < 256; i++) pc += int'(key_w[i]);
    klen_w = 9'd256;
    @(negedge clk);
    i_valid_w = 1'b1;
    @(negedge clk);
    i_valid_w = 1'b0;
    n = 0;
    while (!o_valid_w && n < 80000) begin
      @(negedge clk);
      n++;
    end
    chk("w256 latency", 256'(n), 256'((3 + pc + 255) * 257));
    chk("w256 out", o_out_w, exp_w);
    @(negedge clk);
    chk("w256 idle", 256'({i_ready_w, o_valid_w}), 256'(2'b10));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
